// File: rtl/pipe_pkg.sv
// Shared widths, decoded-control bit positions and ID/EX stage state encoding
// for the 5-stage core pipeline.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;
    localparam int NUM_SRC    = 2;
    localparam int CNT_W      = 16;

    // Bit positions inside the packed control bundle; bit 15 is spare.
    localparam int CTRL_REGWRITE     = 0;
    localparam int CTRL_ALUSRC       = 1;
    localparam int CTRL_MEMWRITE     = 2;
    localparam int CTRL_RESULTSRC_LO = 3;
    localparam int CTRL_RESULTSRC_HI = 4;
    localparam int CTRL_BRANCH       = 5;
    localparam int CTRL_JUMP         = 6;
    localparam int CTRL_JALR         = 7;
    localparam int CTRL_ALUCTRL_LO   = 8;
    localparam int CTRL_ALUCTRL_HI   = 11;
    localparam int CTRL_FUNCT3_LO    = 12;
    localparam int CTRL_FUNCT3_HI    = 14;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/id_ex_slot.sv
// One ID/EX payload register with valid bit. Held operands track writeback so
// a stalled instruction never carries stale register data.
module id_ex_slot #(
    parameter int XLEN       = pipe_pkg::XLEN,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CTRL_W     = pipe_pkg::CTRL_W,
    parameter int NUM_SRC    = pipe_pkg::NUM_SRC
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic                          clr_i,
    input  logic [CTRL_W-1:0]             ctrl_i,
    input  logic [XLEN-1:0]               pc_i,
    input  logic [XLEN-1:0]               pc4_i,
    input  logic [XLEN-1:0]               imm_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0]         rd_i,
    input  logic [NUM_SRC*XLEN-1:0]       rdata_i,
    input  logic                          wb_we_i,
    input  logic [REG_ADDR_W-1:0]         wb_rd_i,
    input  logic [XLEN-1:0]               wb_data_i,
    output logic                          valid_o,
    output logic [CTRL_W-1:0]             ctrl_o,
    output logic [XLEN-1:0]               pc_o,
    output logic [XLEN-1:0]               pc4_o,
    output logic [XLEN-1:0]               imm_o,
    output logic [NUM_SRC*REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0]         rd_o,
    output logic [NUM_SRC*XLEN-1:0]       rdata_o
);
    import pipe_pkg::*;

    logic                          valid_q;
    logic [CTRL_W-1:0]             ctrl_q;
    logic [XLEN-1:0]               pc_q, pc4_q, imm_q;
    logic [NUM_SRC*REG_ADDR_W-1:0] rs_q, src_rs;
    logic [REG_ADDR_W-1:0]         rd_q;
    logic [NUM_SRC*XLEN-1:0]       rdata_q, rdata_d;

    // The same bypass serves a fresh capture and an entry already held; x0 never matches.
    always_comb begin
        src_rs  = load_i ? rs_i : rs_q;
        rdata_d = load_i ? rdata_i : rdata_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_we_i && (wb_rd_i != '0) &&
                (wb_rd_i == src_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                rdata_d[i*XLEN +: XLEN] = wb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
            imm_q   <= imm_i;
            rs_q    <= rs_i;
            rd_q    <= rd_i;
            rdata_q <= rdata_d;
        end else if (valid_q) begin
            rdata_q <= rdata_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign imm_o   = imm_q;
    assign rs_o    = rs_q;
    assign rd_o    = rd_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// Decode-to-execute stage: valid/ready handshake over a main + skid slot pair,
// with saturating stall and bubble counters.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | main invalid, nothing presented to execute
//   ST_FULL  | main valid, skid invalid
//   ST_SKID  | main and skid valid, in_ready low
module id_ex_skid_stage #(
    parameter int XLEN       = pipe_pkg::XLEN,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CTRL_W     = pipe_pkg::CTRL_W,
    parameter int NUM_SRC    = pipe_pkg::NUM_SRC,
    parameter int CNT_W      = pipe_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CTRL_W-1:0]             in_ctrl,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [XLEN-1:0]               in_pc4,
    input  logic [XLEN-1:0]               in_imm,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0]         in_rd,
    input  logic [NUM_SRC*XLEN-1:0]       in_rdata,
    input  logic                          wb_we,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CTRL_W-1:0]             out_ctrl,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_pc4,
    output logic [XLEN-1:0]               out_imm,
    output logic [NUM_SRC*REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0]         out_rd,
    output logic [NUM_SRC*XLEN-1:0]       out_rdata,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              bubble_cnt
);
    import pipe_pkg::*;

    stage_state_e state;
    logic accept, drain;
    logic main_valid, skid_valid;
    logic main_load, main_clr, skid_load, skid_clr;

    logic [CTRL_W-1:0]             skid_ctrl, main_ctrl_in;
    logic [XLEN-1:0]               skid_pc, skid_pc4, skid_imm;
    logic [XLEN-1:0]               main_pc_in, main_pc4_in, main_imm_in;
    logic [NUM_SRC*REG_ADDR_W-1:0] skid_rs, main_rs_in;
    logic [REG_ADDR_W-1:0]         skid_rd, main_rd_in;
    logic [NUM_SRC*XLEN-1:0]       skid_rdata, main_rdata_in;

    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

    // in_ready comes from a flop only, so there is no path from out_ready.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    always_comb begin
        if (skid_valid)      state = ST_SKID;
        else if (main_valid) state = ST_FULL;
        else                 state = ST_EMPTY;

        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_FULL: begin
                    if (drain) begin
                        main_load = accept;
                        main_clr  = !accept;
                    end else begin
                        skid_load = accept;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Main only ever reloads from the skid slot while that slot is occupied.
    assign main_ctrl_in  = skid_valid ? skid_ctrl  : in_ctrl;
    assign main_pc_in    = skid_valid ? skid_pc    : in_pc;
    assign main_pc4_in   = skid_valid ? skid_pc4   : in_pc4;
    assign main_imm_in   = skid_valid ? skid_imm   : in_imm;
    assign main_rs_in    = skid_valid ? skid_rs    : in_rs;
    assign main_rd_in    = skid_valid ? skid_rd    : in_rd;
    assign main_rdata_in = skid_valid ? skid_rdata : in_rdata;

    id_ex_slot #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W), .NUM_SRC(NUM_SRC)
    ) u_main (
        .clk_i(clk), .rst_i(rst), .load_i(main_load), .clr_i(main_clr),
        .ctrl_i(main_ctrl_in), .pc_i(main_pc_in), .pc4_i(main_pc4_in),
        .imm_i(main_imm_in), .rs_i(main_rs_in), .rd_i(main_rd_in),
        .rdata_i(main_rdata_in),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .valid_o(main_valid), .ctrl_o(out_ctrl), .pc_o(out_pc), .pc4_o(out_pc4),
        .imm_o(out_imm), .rs_o(out_rs), .rd_o(out_rd), .rdata_o(out_rdata)
    );

    id_ex_slot #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W), .NUM_SRC(NUM_SRC)
    ) u_skid (
        .clk_i(clk), .rst_i(rst), .load_i(skid_load), .clr_i(skid_clr),
        .ctrl_i(in_ctrl), .pc_i(in_pc), .pc4_i(in_pc4), .imm_i(in_imm),
        .rs_i(in_rs), .rd_i(in_rd), .rdata_i(in_rdata),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .valid_o(skid_valid), .ctrl_o(skid_ctrl), .pc_o(skid_pc), .pc4_o(skid_pc4),
        .imm_o(skid_imm), .rs_o(skid_rs), .rd_o(skid_rd), .rdata_o(skid_rdata)
    );

    // Counters look at the pre-flush view of out_valid.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_valid && !out_ready && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
        if (out_ready && !main_valid && (bubble_q != '1))
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule
